div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 28 ++
 rtl/div_ctrl.sv | 164 ++++++++++++++++
 tb/tb_div_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the iterative divider: state encodings, handshake levels
// and operand widths, plus a conditional two's-complement helper.
package div_ctrl_pkg;

    localparam int Reg        = 32;
    localparam int Reg_Double = 64;

    localparam logic Rst_Enable        = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [Reg-1:0] Zero_Word   = 32'h0000_0000;
    localparam logic [5:0]     DivIterLast = 6'd32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    function automatic logic [Reg-1:0] neg_if(input logic [Reg-1:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU: 32 iterations on magnitudes,
// then sign fix-up; result is {remainder, quotient} held until start_i drops.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [Reg-1:0]        opdata1_i,
    input  logic [Reg-1:0]        opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [Reg_Double-1:0] result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    div_state_e            r_state;
    logic [5:0]            r_cnt;
    logic [64:0]           r_shift;
    logic [Reg-1:0]        r_divisor;
    logic                  r_sign1;
    logic                  r_sign2;
    logic                  r_signed;
    logic [Reg_Double-1:0] r_result;
    logic                  r_ready;
    logic                  r_busy;

    div_state_e            w_state_next;
    logic [5:0]            w_cnt_next;
    logic [64:0]           w_shift_next;
    logic [Reg-1:0]        w_divisor_next;
    logic                  w_sign1_next;
    logic                  w_sign2_next;
    logic                  w_signed_next;
    logic [Reg_Double-1:0] w_result_next;
    logic                  w_ready_next;
    logic                  w_busy_next;
    logic [32:0]           w_trial;
    logic                  w_take;
    logic [Reg-1:0]        w_quo;
    logic [Reg-1:0]        w_rem;

    // Partial remainder sits in r_shift[64:33]; the trial window is that value
    // shifted left with the next dividend bit. Bit 64 set means the window
    // already exceeds any 32-bit divisor, so the subtraction must succeed.
    assign w_trial = r_shift[64:32] - {1'b0, r_divisor};
    assign w_take  = r_shift[64] | ~w_trial[32];
    assign w_quo   = r_shift[31:0];
    assign w_rem   = r_shift[64:33];

    // Next-state, datapath and output-register values.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_shift_next   = r_shift;
        w_divisor_next = r_divisor;
        w_sign1_next   = r_sign1;
        w_sign2_next   = r_sign2;
        w_signed_next  = r_signed;
        w_result_next  = r_result;
        w_ready_next   = r_ready;
        case (r_state)
            DivFree: begin
                w_result_next = {Zero_Word, Zero_Word};
                w_ready_next  = DivResultNotReady;
                if ((start_i == DivStart) && !annul_i) begin
                    w_signed_next  = signed_div_i;
                    w_sign1_next   = opdata1_i[31];
                    w_sign2_next   = opdata2_i[31];
                    w_divisor_next = neg_if(opdata2_i, signed_div_i & opdata2_i[31]);
                    w_shift_next   = {Zero_Word, neg_if(opdata1_i, signed_div_i & opdata1_i[31]), 1'b0};
                    w_cnt_next     = 6'd0;
                    if (opdata2_i == Zero_Word) begin
                        w_state_next = DivByZero;
                    end else begin
                        w_state_next = DivOn;
                    end
                end else begin
                    w_state_next = DivFree;
                end
            end
            DivByZero: begin
                w_result_next = {Zero_Word, Zero_Word};
                if (annul_i) begin
                    w_state_next = DivFree;
                    w_ready_next = DivResultNotReady;
                end else begin
                    w_state_next = DivEnd;
                    w_ready_next = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    w_state_next  = DivFree;
                    w_ready_next  = DivResultNotReady;
                    w_result_next = {Zero_Word, Zero_Word};
                    w_cnt_next    = 6'd0;
                end else if (r_cnt != DivIterLast) begin
                    w_cnt_next = r_cnt + 6'd1;
                    if (w_take) begin
                        w_shift_next = {w_trial[31:0], r_shift[31:0], 1'b1};
                    end else begin
                        w_shift_next = {r_shift[63:0], 1'b0};
                    end
                end else begin
                    w_state_next  = DivEnd;
                    w_ready_next  = DivResultReady;
                    w_cnt_next    = 6'd0;
                    w_result_next = {neg_if(w_rem, r_signed & r_sign1),
                                     neg_if(w_quo, r_signed & (r_sign1 ^ r_sign2))};
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_next  = DivFree;
                    w_ready_next  = DivResultNotReady;
                    w_result_next = {Zero_Word, Zero_Word};
                end else begin
                    w_state_next = DivEnd;
                end
            end
            default: begin
                w_state_next  = DivFree;
                w_ready_next  = DivResultNotReady;
                w_result_next = {Zero_Word, Zero_Word};
                w_cnt_next    = 6'd0;
            end
        endcase
        w_busy_next = (w_state_next == DivOn) || (w_state_next == DivByZero);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (rst == Rst_Enable) begin
            r_state   <= DivFree;
            r_cnt     <= 6'd0;
            r_shift   <= 65'd0;
            r_divisor <= Zero_Word;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            r_result  <= {Zero_Word, Zero_Word};
            r_ready   <= DivResultNotReady;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_divisor <= w_divisor_next;
            r_sign1   <= w_sign1_next;
            r_sign2   <= w_sign2_next;
            r_signed  <= w_signed_next;
            r_result  <= w_result_next;
            r_ready   <= w_ready_next;
            r_busy    <= w_busy_next;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a cycle-level reference model built from plain
// arithmetic and countdowns, checked every cycle, plus literal expectations.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // Reference model: countdown from acceptance to ready, then hold until start drops.
    int          m_left   = 0;
    logic        m_ready  = 1'b0;
    logic        m_busy   = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_pend   = 64'd0;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_left   <= 0;
            m_ready  <= 1'b0;
            m_busy   <= 1'b0;
            m_result <= 64'd0;
        end else if (m_ready) begin
            if (!start_i) begin
                m_ready  <= 1'b0;
                m_result <= 64'd0;
            end
        end else if (m_left > 0) begin
            if (annul_i) begin
                m_left <= 0;
                m_busy <= 1'b0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_ready  <= 1'b1;
                    m_busy   <= 1'b0;
                    m_result <= m_pend;
                end
            end
        end else if (start_i && !annul_i) begin
            m_pend <= ref_div(signed_div_i, opdata1_i, opdata2_i);
            m_left <= (opdata2_i == 32'd0) ? 1 : 33;
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", {63'd0, ready_o}, {63'd0, m_ready});
            chk("busy", {63'd0, busy_o}, {63'd0, m_busy});
            chk("result", result_o, m_result);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int exp_lat, input int hold_n);
        int lat  = 0;
        bit seen = 1'b0;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        while (!seen && lat < 40) begin
            step();
            lat++;
            if (lat == 1) begin
                opdata1_i    = ~a;
                opdata2_i    = b ^ 32'h5A5A_0003;
                signed_div_i = ~s;
            end
            if (ready_o === 1'b1) seen = 1'b1;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, result_o, exp);
        for (int i = 0; i < hold_n; i++) begin
            step();
            chk({name, " hold"}, {63'd0, ready_o}, 64'd1);
            annul_i = (i == 1);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        step();
        chk({name, " release"}, {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        step();
        step();
        cmp_en = 1'b1;
        chk("reset ready", {63'd0, ready_o}, 64'd0);
        chk("reset busy", {63'd0, busy_o}, 64'd0);
        chk("reset result", result_o, 64'd0);
        rst = 1'b1;
        step();

        // annul held in FREE must block acceptance
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("annul in free", {63'd0, busy_o}, 64'd0);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        step();

        run_div("u 100/7",      1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 34, 0);
        run_div("s -7/2",       1'b1, 32'hFFFF_FFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD, 34, 0);
        run_div("s 7/-2",       1'b1, 32'd7,         32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34, 0);
        run_div("s -100/-7",    1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 34, 0);
        run_div("s min/-1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34, 0);
        run_div("u max/1",      1'b0, 32'hFFFF_FFFF, 32'd1,         64'h00000000_FFFFFFFF, 34, 0);
        run_div("u max/big",    1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFFFFFE_00000001, 34, 0);
        run_div("u by zero",    1'b0, 32'd1234,      32'd0,         64'd0,                  2, 5);
        run_div("s by zero",    1'b1, 32'hFFFF_FFFB, 32'd0,         64'd0,                  2, 0);

        // annul during iteration: cycle N+10
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int i = 0; i < 10; i++) step();
        annul_i = 1'b1;
        start_i = 1'b0;
        step();
        annul_i = 1'b0;
        chk("annul busy", {63'd0, busy_o}, 64'd0);
        chk("annul ready", {63'd0, ready_o}, 64'd0);
        chk("annul result", result_o, 64'd0);
        for (int i = 0; i < 40; i++) step();
        chk("annul no ready", {63'd0, ready_o}, 64'd0);
        run_div("u 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 0);

        // reset during iteration: cycle N+20
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rst     = 1'b0;
        start_i = 1'b0;
        step();
        chk("midrst ready", {63'd0, ready_o}, 64'd0);
        chk("midrst busy", {63'd0, busy_o}, 64'd0);
        chk("midrst result", result_o, 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("midrst no ready", {63'd0, ready_o}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
